// File: rtl/ma3_decim_fifo.sv
// ---------------------------------------------------------------------------
// ma3_decim_fifo
//
// Purpose:
//   Downstream stage of the 3-tap moving-average filter. It keeps one of every
//   DECIM valid input samples and buffers the kept samples in a small
//   first-word-fall-through FIFO. A consumer reads the FIFO through a
//   valid/ready handshake. The filter side has no backpressure. A kept sample
//   that arrives while the FIFO is full and not being popped is dropped. That
//   drop sets a sticky overflow flag.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, >= 2)
//   DECIM  keep one of every DECIM valid samples (1..255, 1 = keep all)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    in_sample is valid this cycle
//   in_sample   signed 8-bit sample from the filter
//   flush       synchronous clear of FIFO contents and decimation phase
//   out_valid   FIFO head is valid
//   out_ready   consumer accepts the head this cycle
//   out_sample  signed FIFO head (0 when empty)
//   level       number of stored entries, 0..DEPTH
//   overflow    sticky: a kept sample was dropped (cleared by rst only)
//   drop_count  (only with MA3_DECIM_FIFO_DROP_COUNT_EN) saturating 16-bit
//               count of dropped samples, cleared by rst only
//
// Optional feature macro: MA3_DECIM_FIFO_DROP_COUNT_EN
// ---------------------------------------------------------------------------
module ma3_decim_fifo #(
    parameter int DEPTH = 4,
    parameter int DECIM = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [7:0]               in_sample,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_sample,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
`ifdef MA3_DECIM_FIFO_DROP_COUNT_EN
    ,
    output logic [15:0]              drop_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = 8;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          overflow_q, overflow_d;

    logic kept;
    logic full;
    logic pop;
    logic push;
    logic drop;
    logic wr_en;

    assign out_valid  = (level_q != '0);
    assign out_sample = out_valid ? mem_q[rd_ptr_q] : 8'd0;
    assign level      = level_q;
    assign overflow   = overflow_q;

    always_comb begin
        full  = (level_q == LW'(DEPTH));
        pop   = out_valid & out_ready;
        kept  = in_valid & (phase_q == '0);
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        push  = kept & (~full | pop);
        drop  = kept & full & ~pop;
        // A flush discards the incoming sample as well as the stored ones.
        wr_en = push & ~flush;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        phase_d    = phase_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            phase_d  = '0;
        end else begin
            if (in_valid) begin
                phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            level_d = level_q + LW'(push) - LW'(pop);
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            phase_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            phase_q    <= phase_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage has no reset; entries are only visible once level covers them.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_ptr_q] <= in_sample;
        end
    end

`ifdef MA3_DECIM_FIFO_DROP_COUNT_EN
    logic [15:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        if (!flush && drop && drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count_q <= 16'd0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_ma3_decim_fifo.sv
// ---------------------------------------------------------------------------
// tb_ma3_decim_fifo
//
// Three instances of ma3_decim_fifo (DEPTH=4, DECIM=1,2,3) share one stimulus
// stream. A queue-based reference model per instance predicts every output.
// ---------------------------------------------------------------------------
module tb_ma3_decim_fifo;

    localparam int DEPTH = 4;
    localparam int NI    = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_sample;
    logic       flush;
    logic       out_ready;

    logic       dut_valid  [NI];
    logic [7:0] dut_sample [NI];
    logic [2:0] dut_level  [NI];
    logic       dut_ovf    [NI];
`ifdef MA3_DECIM_FIFO_DROP_COUNT_EN
    logic [15:0] dut_dc    [NI];
`endif

    // Reference model state
    logic [7:0] m_data [NI][$];
    int         m_phase [NI];
    logic       m_ovf [NI];
    int         m_dc [NI];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        ma3_decim_fifo #(.DEPTH(DEPTH), .DECIM(gi + 1)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_sample  (in_sample),
            .flush      (flush),
            .out_valid  (dut_valid[gi]),
            .out_ready  (out_ready),
            .out_sample (dut_sample[gi]),
            .level      (dut_level[gi]),
            .overflow   (dut_ovf[gi])
`ifdef MA3_DECIM_FIFO_DROP_COUNT_EN
            ,
            .drop_count (dut_dc[gi])
`endif
        );
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_sample(int k);
        return (m_data[k].size() != 0) ? m_data[k][0] : 8'd0;
    endfunction

    // Reference model: one clock edge of behaviour, from the rules on levels,
    // decimation phase, drop and flush.
    task automatic model_update();
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                m_data[k].delete();
                m_phase[k] = 0;
                m_ovf[k]   = 1'b0;
                m_dc[k]    = 0;
            end else if (flush) begin
                m_data[k].delete();
                m_phase[k] = 0;
            end else begin
                bit do_pop;
                bit is_kept;
                do_pop  = (m_data[k].size() != 0) && out_ready;
                is_kept = in_valid && (m_phase[k] == 0);
                if (in_valid) m_phase[k] = (m_phase[k] + 1) % (k + 1);
                if (do_pop) void'(m_data[k].pop_front());
                if (is_kept) begin
                    if (m_data[k].size() < DEPTH) begin
                        m_data[k].push_back(in_sample);
                    end else begin
                        m_ovf[k] = 1'b1;
                        if (m_dc[k] != 65535) m_dc[k]++;
                    end
                end
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, clock, and settle.
    task automatic step(input logic v, input logic [7:0] s, input logic r,
                        input logic f, input logic rs);
        in_valid  = v;
        in_sample = s;
        out_ready = r;
        flush     = f;
        rst       = rs;
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < NI; k++) begin
            n_vec++;
            if (dut_valid[k] !== 1'b0 || dut_sample[k] !== 8'd0 ||
                dut_level[k] !== 3'd0 || dut_ovf[k] !== 1'b0) begin
                n_err++;
                $display("FAIL reset[%0d]: got v=%b s=%h l=%0d o=%b want v=0 s=00 l=0 o=0",
                         k, dut_valid[k], dut_sample[k], dut_level[k], dut_ovf[k]);
            end
        end
    endtask

    task automatic test_drain();
        logic [7:0] vals [4];
        vals = '{8'h05, 8'hFD, 8'h7F, 8'h80};
        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, vals[i], 1'b1, 1'b0, 1'b0);
            n_vec++;
            if (dut_valid[0] !== 1'b1 || dut_sample[0] !== vals[i] ||
                dut_level[0] !== 3'd1 || dut_ovf[0] !== 1'b0) begin
                n_err++;
                $display("FAIL drain[%0d]: got v=%b s=%h l=%0d o=%b want v=1 s=%h l=1 o=0",
                         i, dut_valid[0], dut_sample[0], dut_level[0], dut_ovf[0], vals[i]);
            end
        end
        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (dut_valid[0] !== 1'b0 || dut_level[0] !== 3'd0) begin
            n_err++;
            $display("FAIL drain_empty: got v=%b l=%0d want v=0 l=0", dut_valid[0], dut_level[0]);
        end
    endtask

    task automatic test_decim();
        logic [7:0] got [$];
        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
            if (dut_valid[2]) got.push_back(dut_sample[2]);
            if (i == 4) begin
                step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
                if (dut_valid[2]) got.push_back(dut_sample[2]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
            if (dut_valid[2]) got.push_back(dut_sample[2]);
        end
        n_vec++;
        if (got.size() != 3) begin
            n_err++;
            $display("FAIL decim_count: got %0d outputs want 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (got[i] !== 8'(3 * i + 1)) begin
                    n_err++;
                    $display("FAIL decim_val[%0d]: got %0d want %0d", i, got[i], 3 * i + 1);
                end
            end
        end
    endtask

    task automatic test_overflow();
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) step(1'b1, 8'(10 * i), 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (dut_level[0] !== 3'd4 || dut_ovf[0] !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_full: got l=%0d o=%b want l=4 o=1", dut_level[0], dut_ovf[0]);
        end
`ifdef MA3_DECIM_FIFO_DROP_COUNT_EN
        n_vec++;
        if (dut_dc[0] !== 16'd1) begin
            n_err++;
            $display("FAIL ovf_dropcount: got %0d want 1", dut_dc[0]);
        end
`endif
        for (int i = 1; i <= 4; i++) begin
            n_vec++;
            if (dut_valid[0] !== 1'b1 || dut_sample[0] !== 8'(10 * i)) begin
                n_err++;
                $display("FAIL ovf_drain[%0d]: got v=%b s=%0d want v=1 s=%0d",
                         i, dut_valid[0], dut_sample[0], 10 * i);
            end
            step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        end
        n_vec++;
        if (dut_level[0] !== 3'd0 || dut_ovf[0] !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_empty: got l=%0d o=%b want l=0 o=1", dut_level[0], dut_ovf[0]);
        end
    endtask

    task automatic test_full_pushpop();
        logic [7:0] exp_order [4];
        exp_order = '{8'd2, 8'd3, 8'd4, 8'd9};
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'd9, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (dut_level[0] !== 3'd4 || dut_ovf[0] !== 1'b0) begin
            n_err++;
            $display("FAIL pushpop_full: got l=%0d o=%b want l=4 o=0", dut_level[0], dut_ovf[0]);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (dut_sample[0] !== exp_order[i]) begin
                n_err++;
                $display("FAIL pushpop_order[%0d]: got %0d want %0d", i, dut_sample[0], exp_order[i]);
            end
            step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_flush();
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        // DECIM=2: nine samples keep 1,3,5,7,9 -> four stored, 9 dropped, phase=1
        for (int i = 1; i <= 9; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (dut_level[1] !== 3'd3 || dut_ovf[1] !== 1'b1) begin
            n_err++;
            $display("FAIL flush_setup: got l=%0d o=%b want l=3 o=1", dut_level[1], dut_ovf[1]);
        end
        step(1'b1, 8'd77, 1'b1, 1'b1, 1'b0);
        n_vec++;
        if (dut_level[1] !== 3'd0 || dut_valid[1] !== 1'b0 || dut_ovf[1] !== 1'b1) begin
            n_err++;
            $display("FAIL flush_clear: got l=%0d v=%b o=%b want l=0 v=0 o=1",
                     dut_level[1], dut_valid[1], dut_ovf[1]);
        end
        step(1'b1, 8'd55, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (dut_level[1] !== 3'd1 || dut_sample[1] !== 8'd55) begin
            n_err++;
            $display("FAIL flush_phase: got l=%0d s=%0d want l=1 s=55", dut_level[1], dut_sample[1]);
        end
    endtask

    task automatic test_backpressure();
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hD6, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (dut_valid[0] !== 1'b1 || dut_sample[0] !== 8'hD6) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got v=%b s=%h want v=1 s=d6", i, dut_valid[0], dut_sample[0]);
            end
            step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (dut_valid[0] !== 1'b0 || dut_level[0] !== 3'd0) begin
            n_err++;
            $display("FAIL bp_pop: got v=%b l=%0d want v=0 l=0", dut_valid[0], dut_level[0]);
        end
    endtask

    task automatic test_rst_mid();
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < NI; k++) begin
            n_vec++;
            if (dut_valid[k] !== 1'b0 || dut_sample[k] !== 8'd0 ||
                dut_level[k] !== 3'd0 || dut_ovf[k] !== 1'b0) begin
                n_err++;
                $display("FAIL rst_mid[%0d]: got v=%b s=%h l=%0d o=%b want all 0",
                         k, dut_valid[k], dut_sample[k], dut_level[k], dut_ovf[k]);
            end
`ifdef MA3_DECIM_FIFO_DROP_COUNT_EN
            n_vec++;
            if (dut_dc[k] !== 16'd0) begin
                n_err++;
                $display("FAIL rst_mid_dc[%0d]: got %0d want 0", k, dut_dc[k]);
            end
`endif
        end
    endtask

    task automatic test_random();
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 50) == 0, $urandom_range(0, 200) == 0);
            for (int k = 0; k < NI; k++) begin
                n_vec++;
                if (dut_level[k] !== 3'(m_data[k].size())) begin
                    n_err++;
                    $display("FAIL rand_level[%0d] cyc %0d: got %0d want %0d",
                             k, c, dut_level[k], m_data[k].size());
                end
                n_vec++;
                if (dut_valid[k] !== (m_data[k].size() != 0) || dut_sample[k] !== exp_sample(k)) begin
                    n_err++;
                    $display("FAIL rand_head[%0d] cyc %0d: got v=%b s=%h want v=%b s=%h",
                             k, c, dut_valid[k], dut_sample[k], m_data[k].size() != 0, exp_sample(k));
                end
                n_vec++;
                if (dut_ovf[k] !== m_ovf[k]) begin
                    n_err++;
                    $display("FAIL rand_ovf[%0d] cyc %0d: got %b want %b", k, c, dut_ovf[k], m_ovf[k]);
                end
`ifdef MA3_DECIM_FIFO_DROP_COUNT_EN
                n_vec++;
                if (dut_dc[k] !== 16'(m_dc[k])) begin
                    n_err++;
                    $display("FAIL rand_dc[%0d] cyc %0d: got %0d want %0d", k, c, dut_dc[k], m_dc[k]);
                end
`endif
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sample = 8'd0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_drain();
        test_decim();
        test_overflow();
        test_full_pushpop();
        test_flush();
        test_backpressure();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ma3_decim_fifo.md
Name: ma3_decim_fifo

Overview:
Downstream stage of the 3-tap moving-average filter. It consumes the filter's signed 8-bit output stream, which is valid one sample per qualifying cycle and has no backpressure. It decimates the stream by a fixed ratio and buffers the kept samples in a small first-word-fall-through FIFO. The FIFO is read through a valid/ready handshake by the next consumer, e.g. a serializer or DMA.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- DECIM, 1: keep one of every DECIM input samples; range 1..255 (1 = keep all).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_sample is valid this cycle; no ready is returned to the filter.
- in_sample  input  8  signed sample from the moving-average filter.
- flush  input  1  synchronous clear of FIFO contents and decimation phase.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer accepts the head this cycle.
- out_sample  output  8  signed FIFO head.
- level  output  $clog2(DEPTH)+1  registered count of stored entries, 0..DEPTH.
- overflow  output  1  sticky flag: a kept sample was dropped.

Behaviour:
- Clock and reset: one clock domain, clk; reset rst is synchronous, active-high.
- Reset values:
  - wr_ptr, rd_ptr, level, phase = 0.
  - out_valid = 0, overflow = 0, out_sample = 0.
  - Memory contents are don't-care.
- Decimation phase counter, 0..DECIM-1:
  - Advances by 1 on every in_valid cycle; wraps DECIM-1 -> 0.
  - A sample is "kept" when in_valid=1 and phase==0.
  - With DECIM=1 every valid sample is kept.
- Pop: pop = out_valid & out_ready.
- Push: push = kept & (level<DEPTH | pop).
  - When full, a simultaneous pop frees the slot, so the write succeeds.
- Drop: drop = kept & level==DEPTH & !pop.
  - Sample is discarded and overflow is set to 1.
  - overflow stays 1 until rst; flush does not clear it.
- level update: level_next = level + push - pop.
  - Push and pop in the same cycle leave level unchanged.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- out_valid = (level != 0), registered via level.
- out_sample = mem[rd_ptr] when out_valid, else 0 (combinational from registered state).
- Latency: a sample kept in cycle N is visible on out_valid/out_sample in cycle N+1 when the FIFO was empty.
- Handshake rules:
  - out_sample is held stable while out_valid=1 and out_ready=0.
  - out_ready while out_valid=0 has no effect.
- flush=1, taking effect at the next edge:
  - level = 0, pointers = 0, phase = 0.
  - Any same-cycle push or pop is ignored.
  - overflow is retained.
- Priority: rst > flush > push/pop.
- Arithmetic: samples are stored bit-exact; no resizing or saturation. Signedness is preserved on out_sample.

Optional Feature:
Macro: MA3_DECIM_FIFO_DROP_COUNT_EN.
- Defined:
  - Adds output port drop_count, 16 bits, unsigned.
  - Increments on each drop cycle and saturates at 16'hFFFF.
  - Reset to 0 by rst only; flush does not affect it.
  - overflow behaves as specified above.
- Undefined: port and counter are absent. Interface and behaviour are otherwise identical.

Test Plan:
1. Reset and drain, DECIM=1, DEPTH=4, out_ready=1:
   - Stimulus: assert rst for 2 cycles, then drive in_sample = 5, -3, 127, -128 on consecutive cycles.
   - Required: out_sample = 5, -3, 127, -128, each one cycle after input; level never exceeds 1; overflow = 0.
2. Decimation, DECIM=3:
   - Stimulus: valid inputs 1..9 with a 1-cycle in_valid gap after sample 4, out_ready=1.
   - Required: outputs exactly 1, 4, 7; phase is unaffected by the gap.
3. Full/overflow, DEPTH=4, out_ready=0:
   - Stimulus: write 10, 20, 30, 40, 50.
   - Required: level=4; overflow=1 after 50; then out_ready=1 yields 10, 20, 30, 40 and level returns to 0.
   - With MA3_DECIM_FIFO_DROP_COUNT_EN: drop_count=1.
4. Simultaneous push and pop at full:
   - Stimulus: level=4 holding 1, 2, 3, 4; in_sample=9 with out_ready=1 in the same cycle.
   - Required: level stays 4, overflow stays 0, drain order is 2, 3, 4, 9.
5. Flush mid-operation:
   - Stimulus: level=3 with overflow=1, DECIM=2, phase=1; pulse flush with in_valid=1 and in_sample=77 in the same cycle.
   - Required: next cycle level=0, out_valid=0, overflow=1, 77 is not stored; the next valid sample is kept (phase=0).
6. Backpressure stability:
   - Stimulus: single entry -42 with out_ready=0 for 5 cycles.
   - Required: out_valid=1 and out_sample=-42 constant; pops on the first cycle out_ready=1, then out_valid=0.
   - Stimulus: rst asserted mid-stream.
   - Required: all outputs return to reset values next cycle.
